// File: rtl/vc_link_tx_pkg.sv
// rtl/vc_link_tx_pkg.sv - shared NoC link constants and types
package vc_link_tx_pkg;

    localparam int NUM_VC     = 4;
    localparam int FLIT_WIDTH = 128;
    localparam int VC_DEPTH   = 32;
    localparam int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CRED_W     = $clog2(VC_DEPTH + 1);

    typedef logic [FLIT_WIDTH-1:0] flit_t;
    typedef logic [VC_W-1:0]       vc_id_t;
    typedef logic [CRED_W-1:0]     cred_t;

endpackage

// File: rtl/vc_link_tx_if.sv
// rtl/vc_link_tx_if.sv - switch-side flit handshake, link output and credit return
interface vc_link_tx_if;
    import vc_link_tx_pkg::*;

    logic [NUM_VC-1:0]            in_valid;
    logic [NUM_VC*FLIT_WIDTH-1:0] in_flit;
    logic [NUM_VC-1:0]            in_ready;
    logic [NUM_VC-1:0]            credit_in;
    logic                         link_valid;
    flit_t                        link_flit;
    vc_id_t                       link_vc;

    modport master (
        output in_valid, in_flit, credit_in,
        input  in_ready, link_valid, link_flit, link_vc
    );

    modport slave (
        input  in_valid, in_flit, credit_in,
        output in_ready, link_valid, link_flit, link_vc
    );

endinterface

// File: rtl/vc_link_tx_rr_arbiter.sv
// rtl/vc_link_tx_rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_gnt_idx
);

    logic w_found;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(i_ptr) + i;
            if (j >= N) j = j - N;
            if (!w_found && i_req[j]) begin
                w_found   = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = W'(j);
            end
        end
    end

endmodule

// File: rtl/vc_link_tx.sv
// rtl/vc_link_tx.sv - credit-based per-VC link transmitter with round-robin VC selection
module vc_link_tx
    import vc_link_tx_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    vc_link_tx_if.slave              bus,
    output logic [NUM_VC*CRED_W-1:0] o_credit_cnt,
    output logic                     o_err_credit_ovf
);

    cred_t             r_cnt [NUM_VC];
    vc_id_t            r_ptr;
    logic              r_link_valid;
    flit_t             r_link_flit;
    vc_id_t            r_link_vc;
    logic              r_err;

    logic [NUM_VC-1:0] w_elig;
    logic [NUM_VC-1:0] w_gnt;
    vc_id_t            w_gnt_idx;
    vc_id_t            w_ptr_next;
    logic              w_any;

    // Registered counters only: a credit returned this cycle is usable next cycle.
    always_comb begin
        w_elig = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_elig[v] = bus.in_valid[v] && (r_cnt[v] != '0);
        end
    end

    rr_arbiter #(.N(NUM_VC)) u_arb (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign w_any      = |w_gnt;
    assign w_ptr_next = (w_gnt_idx == vc_id_t'(NUM_VC - 1)) ? '0 : vc_id_t'(w_gnt_idx + 1'b1);
    assign bus.in_ready = rst_n ? w_gnt : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_link_valid <= 1'b0;
            r_link_flit  <= '0;
            r_link_vc    <= '0;
            r_err        <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) r_cnt[v] <= cred_t'(VC_DEPTH);
        end else begin
            r_link_valid <= w_any;
            if (w_any) begin
                r_link_flit <= bus.in_flit[w_gnt_idx*FLIT_WIDTH +: FLIT_WIDTH];
                r_link_vc   <= w_gnt_idx;
                r_ptr       <= w_ptr_next;
            end
            for (int v = 0; v < NUM_VC; v++) begin
                case ({w_gnt[v], bus.credit_in[v]})
                    2'b10: r_cnt[v] <= r_cnt[v] - 1'b1;
                    2'b01: begin
                        // Saturate rather than wrap; a surplus credit means upstream/downstream disagree.
                        if (r_cnt[v] == cred_t'(VC_DEPTH)) r_err    <= 1'b1;
                        else                               r_cnt[v] <= r_cnt[v] + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.link_valid  = r_link_valid;
    assign bus.link_flit   = r_link_flit;
    assign bus.link_vc     = r_link_vc;
    assign o_err_credit_ovf = r_err;

    always_comb begin
        o_credit_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) o_credit_cnt[v*CRED_W +: CRED_W] = r_cnt[v];
    end

endmodule

// File: tb/tb_vc_link_tx.sv
// tb/tb_vc_link_tx.sv - directed and randomized checks of vc_link_tx against a credit/round-robin model
module tb_vc_link_tx;
    import vc_link_tx_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_link_tx_if u_if ();
    logic [NUM_VC*CRED_W-1:0] credit_cnt;
    logic                     err;

    vc_link_tx dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (u_if.slave),
        .o_credit_cnt     (credit_cnt),
        .o_err_credit_ovf (err)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: credits held, next-priority VC, expected link register, sticky flag
    int    m_cnt [NUM_VC];
    int    m_ptr;
    bit    m_lv;
    int    m_lvc;
    flit_t m_lflit;
    bit    m_err;
    int    link_seq[$];

    task automatic chk(string tag, logic [FLIT_WIDTH-1:0] act, logic [FLIT_WIDTH-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NUM_VC; v++) m_cnt[v] = VC_DEPTH;
        m_ptr = 0; m_lv = 0; m_lvc = 0; m_lflit = '0; m_err = 0;
    endtask

    // One clock: inputs are already applied; checks in_ready mid-cycle, then registered state after the edge.
    task automatic cycle();
        int g;
        logic [NUM_VC-1:0] exp_rdy;
        @(negedge clk);
        g = -1;
        if (rst_n) begin
            for (int i = 0; i < NUM_VC; i++) begin
                int v;
                v = (m_ptr + i) % NUM_VC;
                if (g < 0 && u_if.in_valid[v] && m_cnt[v] > 0) g = v;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", u_if.in_ready, exp_rdy);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                bit dec, inc;
                dec = (g == v);
                inc = u_if.credit_in[v];
                if (dec && !inc) m_cnt[v]--;
                else if (inc && !dec) begin
                    if (m_cnt[v] == VC_DEPTH) m_err = 1;
                    else m_cnt[v]++;
                end
            end
            if (g >= 0) begin
                m_lv = 1; m_lvc = g;
                m_lflit = u_if.in_flit[g*FLIT_WIDTH +: FLIT_WIDTH];
                m_ptr = (g + 1) % NUM_VC;
            end else begin
                m_lv = 0;
            end
        end
        #1;
        chk("link_valid", u_if.link_valid, m_lv);
        chk("link_vc", u_if.link_vc, m_lvc);
        chk("link_flit", u_if.link_flit, m_lflit);
        for (int v = 0; v < NUM_VC; v++) chk("credit_cnt", credit_cnt[v*CRED_W +: CRED_W], m_cnt[v]);
        chk("err_ovf", err, m_err);
        if (u_if.link_valid) link_seq.push_back(int'(u_if.link_vc));
    endtask

    task automatic rand_flits();
        for (int v = 0; v < NUM_VC; v++)
            u_if.in_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        u_if.in_valid = '0; u_if.credit_in = '0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int exp_a [8];
        int exp_b [4];
        exp_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_b = '{0, 2, 3, 0};
        model_reset();
        u_if.in_valid = '0; u_if.credit_in = '0; u_if.in_flit = '0;

        // Reset and idle
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("t1_cnt0", credit_cnt[CRED_W-1:0], VC_DEPTH);

        // VC0 streaming with no credit return exhausts after exactly VC_DEPTH flits
        link_seq.delete();
        u_if.in_valid = 4'b0001;
        for (int c = 0; c < 40; c++) begin rand_flits(); cycle(); end
        n = 0;
        foreach (link_seq[i]) if (link_seq[i] == 0) n++;
        chk("t2_flits", n, VC_DEPTH);
        chk("t2_total", link_seq.size(), VC_DEPTH);
        chk("t2_cnt0", credit_cnt[CRED_W-1:0], 0);

        // Single credit: not usable in its own cycle, used once in the next
        u_if.credit_in = 4'b0001;
        cycle();
        u_if.credit_in = '0;
        link_seq.delete();
        cycle();
        cycle();
        chk("t3_grants", link_seq.size(), 1);
        chk("t3_cnt0", credit_cnt[CRED_W-1:0], 0);

        // Round robin across all VCs, then with VC1 out of credits
        do_reset();
        link_seq.delete();
        u_if.in_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin rand_flits(); cycle(); end
        for (int i = 0; i < 8; i++) chk("t4_seq_a", (i < link_seq.size()) ? link_seq[i] : -1, exp_a[i]);
        u_if.in_valid = 4'b0010;
        for (int c = 0; c < VC_DEPTH - 2; c++) begin rand_flits(); cycle(); end
        chk("t4_cnt1", credit_cnt[CRED_W +: CRED_W], 0);
        u_if.in_valid = 4'b1000;
        cycle();
        link_seq.delete();
        u_if.in_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin rand_flits(); cycle(); end
        for (int i = 0; i < 4; i++) chk("t4_seq_b", (i < link_seq.size()) ? link_seq[i] : -1, exp_b[i]);

        // Grant and credit together leave the counter unchanged; surplus credit sets sticky error
        do_reset();
        u_if.in_valid = 4'b0100;
        for (int c = 0; c < VC_DEPTH - 10; c++) begin rand_flits(); cycle(); end
        chk("t5_cnt10", credit_cnt[2*CRED_W +: CRED_W], 10);
        u_if.credit_in = 4'b0100;
        cycle();
        chk("t5_same", credit_cnt[2*CRED_W +: CRED_W], 10);
        u_if.in_valid = '0;
        for (int c = 0; c < VC_DEPTH - 10; c++) cycle();
        chk("t5_full", credit_cnt[2*CRED_W +: CRED_W], VC_DEPTH);
        chk("t5_no_err", err, 1'b0);
        cycle();
        chk("t5_sat", credit_cnt[2*CRED_W +: CRED_W], VC_DEPTH);
        chk("t5_err", err, 1'b1);
        u_if.credit_in = '0;
        repeat (3) cycle();
        chk("t5_sticky", err, 1'b1);

        // Reset mid-burst drops the in-flight flit and refills credits
        do_reset();
        u_if.in_valid = 4'b1111;
        for (int c = 0; c < NUM_VC*(VC_DEPTH-5); c++) begin rand_flits(); cycle(); end
        for (int v = 0; v < NUM_VC; v++) chk("t6_cnt5", credit_cnt[v*CRED_W +: CRED_W], 5);
        rst_n = 1'b0;
        rand_flits();
        cycle();
        chk("t6_lv", u_if.link_valid, 1'b0);
        chk("t6_cnt", credit_cnt[3*CRED_W +: CRED_W], VC_DEPTH);
        rst_n = 1'b1;
        rand_flits();
        cycle();
        chk("t6_vc0", u_if.link_vc, 0);

        // Randomized traffic with credit returns bounded by outstanding credits, rare surplus
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            u_if.in_valid = 4'($urandom);
            for (int v = 0; v < NUM_VC; v++)
                u_if.credit_in[v] = (m_cnt[v] < VC_DEPTH || $urandom_range(0, 199) == 0) && ($urandom_range(0, 2) != 0);
            rand_flits();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
